// File: rtl/vdp_cpu_port.sv
// rtl/vdp_cpu_port.sv - CPU-side access port to the VDP character RAM
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   cpu_wr, cpu_rd      one-cycle CPU strobes (write wins when both are high)
//   cpu_mode            0 = data port, 1 = control/status port
//   cpu_din, cpu_dout   CPU data in / registered CPU data out
//   vram_grant          1 = display has released the RAM this cycle
//   vram_addr, vram_din registered VRAM address / write data
//   vram_we             VRAM write strobe, never high without grant
//   vram_dout           asynchronous VRAM read data
module vdp_cpu_port #(
    parameter int ADDR_W     = 11,
    parameter int CELLS      = 1200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_wr,
    input  logic              cpu_rd,
    input  logic              cpu_mode,
    input  logic [7:0]        cpu_din,
    output logic [7:0]        cpu_dout,
    input  logic              vram_grant,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              vram_we,
    input  logic [7:0]        vram_dout
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] pf_addr;
    logic [7:0]        lo;
    logic [7:0]        rd_buf;
    logic              toggle;
    logic              overflow;
    logic              pf_pending;
    logic              we_r;

    logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
    logic [7:0]        fifo_data [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  head_next;
    logic [PTR_W:0]    count;

    logic              fifo_full;
    logic              fifo_empty;
    logic              busy;
    logic              ctrl_wr;
    logic              data_wr;
    logic              stat_rd;
    logic              data_rd;
    logic              push;
    logic              pop;
    logic              pf_set;
    logic [10:0]       composed;
    logic [ADDR_W-1:0] load_addr;
    logic [ADDR_W-1:0] addr_next;
    logic [ADDR_W-1:0] pf_new;

    assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign fifo_empty = (count == '0);
    assign busy       = !fifo_empty || pf_pending;

    assign ctrl_wr = cpu_wr && cpu_mode;
    assign data_wr = cpu_wr && !cpu_mode;
    assign stat_rd = cpu_rd && !cpu_wr && cpu_mode;
    assign data_rd = cpu_rd && !cpu_wr && !cpu_mode;

    assign push      = data_wr && !fifo_full;
    // The write strobe is gated by grant, so an entry leaves the FIFO only
    // on a cycle where the RAM actually accepted it.
    assign pop       = we_r && vram_grant;
    assign vram_we   = we_r && vram_grant;
    assign head_next = rd_ptr + PTR_W'(1);

    assign composed  = {cpu_din[2:0], lo};
    assign load_addr = (32'(composed) >= CELLS) ? '0 : ADDR_W'(composed);
    assign addr_next = (32'(addr) == CELLS - 1) ? '0 : addr + ADDR_W'(1);

    assign pf_set = data_rd || (ctrl_wr && toggle && !cpu_din[6]);
    assign pf_new = data_rd ? addr_next : load_addr;

    // FIFO storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= addr;
            fifo_data[wr_ptr] <= cpu_din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            cpu_dout   <= '0;
            vram_addr  <= '0;
            vram_din   <= '0;
            we_r       <= 1'b0;
            addr       <= '0;
            pf_addr    <= '0;
            lo         <= '0;
            rd_buf     <= '0;
            toggle     <= 1'b0;
            overflow   <= 1'b0;
            pf_pending <= 1'b0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
        end else begin
            if (ctrl_wr) begin
                if (!toggle) begin
                    lo     <= cpu_din;
                    toggle <= 1'b1;
                end else begin
                    addr   <= load_addr;
                    toggle <= 1'b0;
                end
            end else if (data_wr) begin
                if (fifo_full)
                    overflow <= 1'b1;
                addr   <= addr_next;
                toggle <= 1'b0;
            end else if (stat_rd) begin
                cpu_dout <= {busy, overflow, fifo_full, 5'b0};
                overflow <= 1'b0;
                toggle   <= 1'b0;
            end else if (data_rd) begin
                cpu_dout <= rd_buf;
                addr     <= addr_next;
                toggle   <= 1'b0;
            end

            if (pf_set)
                pf_addr <= pf_new;

            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= head_next;
            case ({push, pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase

            case (state)
                IDLE: begin
                    if (we_r) begin
                        // Stream the following entry while grant holds;
                        // a lost grant aborts and the head is retried.
                        if (vram_grant && count > (PTR_W+1)'(1)) begin
                            vram_addr <= fifo_addr[head_next];
                            vram_din  <= fifo_data[head_next];
                        end else begin
                            we_r <= 1'b0;
                        end
                    end else if (vram_grant && !fifo_empty) begin
                        vram_addr <= fifo_addr[rd_ptr];
                        vram_din  <= fifo_data[rd_ptr];
                        we_r      <= 1'b1;
                    end else if (vram_grant && pf_pending) begin
                        vram_addr <= pf_addr;
                        state     <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    state <= IDLE;
                    // Capture only if the request is still the current one.
                    if (vram_grant && vram_addr == pf_addr && !pf_set) begin
                        rd_buf     <= vram_dout;
                        pf_pending <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // A fresh prefetch request always wins over a completing one.
            if (pf_set)
                pf_pending <= 1'b1;
        end
    end
endmodule

// File: tb/tb_vdp_cpu_port.sv
// tb/tb_vdp_cpu_port.sv - scoreboard bench for vdp_cpu_port
module tb_vdp_cpu_port;
    localparam int CELLS = 1200;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_wr;
    logic        cpu_rd;
    logic        cpu_mode;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        vram_grant;
    logic [10:0] vram_addr;
    logic [7:0]  vram_din;
    logic        vram_we;
    logic [7:0]  vram_dout;

    always #5 clk = ~clk;

    vdp_cpu_port #(.ADDR_W(11), .CELLS(CELLS), .FIFO_DEPTH(4)) dut (
        .clk(clk), .reset(reset), .cpu_wr(cpu_wr), .cpu_rd(cpu_rd),
        .cpu_mode(cpu_mode), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .vram_grant(vram_grant), .vram_addr(vram_addr), .vram_din(vram_din),
        .vram_we(vram_we), .vram_dout(vram_dout)
    );

    // Environment RAM; while the display owns it the bus carries junk.
    logic [7:0] env_mem [0:2047];
    assign vram_dout = vram_grant ? env_mem[vram_addr] : ~env_mem[vram_addr];
    always @(posedge clk) if (vram_we) env_mem[vram_addr] <= vram_din;

    int n_tests = 0;
    int n_fail  = 0;

    logic [18:0] exp_wr [$];
    logic [7:0]  exp_rd [$];

    // Reference model state
    logic [7:0]  m_mem [0:2047];
    logic [18:0] m_q [$];
    logic [10:0] m_addr, m_pfa;
    logic [7:0]  m_lo, m_buf;
    logic        m_tog, m_ovf, m_pf;

    // Write monitor
    always @(negedge clk) begin
        if (vram_we) begin
            n_tests++;
            if (exp_wr.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vram_we: got addr=%h din=%h, required no write", vram_addr, vram_din);
            end else begin
                logic [18:0] e;
                e = exp_wr.pop_front();
                if ({vram_addr, vram_din} !== e || vram_grant !== 1'b1) begin
                    n_fail++;
                    $display("FAIL vram_write: got addr=%h din=%h grant=%b, required addr=%h din=%h grant=1",
                             vram_addr, vram_din, vram_grant, e[18:8], e[7:0]);
                end
            end
        end
    end

    // Read monitor: cpu_dout is due the cycle after an accepted read strobe
    logic rd_seen = 1'b0;
    always @(posedge clk) rd_seen <= cpu_rd & ~cpu_wr & ~reset;
    always @(negedge clk) begin
        if (rd_seen) begin
            n_tests++;
            if (exp_rd.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_read: got cpu_dout=%h, required no read", cpu_dout);
            end else begin
                logic [7:0] e;
                e = exp_rd.pop_front();
                if (cpu_dout !== e) begin
                    n_fail++;
                    $display("FAIL cpu_read: got cpu_dout=%h, required %h", cpu_dout, e);
                end
            end
        end
    end

    function automatic logic [10:0] inc(input logic [10:0] a);
        return (a == 11'(CELLS - 1)) ? 11'd0 : a + 11'd1;
    endfunction

    task automatic strobe(input logic wr, input logic rd, input logic mode, input logic [7:0] din);
        @(posedge clk); #1;
        cpu_wr = wr; cpu_rd = rd; cpu_mode = mode; cpu_din = din;
        @(posedge clk); #1;
        cpu_wr = 1'b0; cpu_rd = 1'b0;
    endtask

    task automatic ctrl_wr(input logic [7:0] d);
        logic [10:0] c;
        if (!m_tog) begin
            m_lo  = d;
            m_tog = 1'b1;
        end else begin
            c      = {d[2:0], m_lo};
            m_addr = (c >= 11'(CELLS)) ? 11'd0 : c;
            m_tog  = 1'b0;
            if (!d[6]) begin
                m_pf  = 1'b1;
                m_pfa = m_addr;
            end
        end
        strobe(1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic data_wr(input logic [7:0] d);
        if (m_q.size() < 4) begin
            m_q.push_back({m_addr, d});
            exp_wr.push_back({m_addr, d});
        end else begin
            m_ovf = 1'b1;
        end
        m_addr = inc(m_addr);
        m_tog  = 1'b0;
        strobe(1'b1, 1'b0, 1'b0, d);
    endtask

    task automatic data_rd();
        exp_rd.push_back(m_buf);
        m_addr = inc(m_addr);
        m_pf   = 1'b1;
        m_pfa  = m_addr;
        m_tog  = 1'b0;
        strobe(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic stat_rd();
        logic b, f;
        b = (m_q.size() != 0) || m_pf;
        f = (m_q.size() == 4);
        exp_rd.push_back({b, m_ovf, f, 5'b0});
        m_ovf = 1'b0;
        m_tog = 1'b0;
        strobe(1'b0, 1'b1, 1'b1, 8'h00);
    endtask

    // Random grant flicker, then solid grant; everything queued must drain.
    task automatic settle();
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            vram_grant = 1'($urandom_range(0, 1));
        end
        vram_grant = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        vram_grant = 1'b0;
        foreach (m_q[i]) m_mem[m_q[i][18:8]] = m_q[i][7:0];
        m_q.delete();
        if (m_pf) begin
            m_buf = m_mem[m_pfa];
            m_pf  = 1'b0;
        end
        n_tests++;
        if (exp_wr.size() != 0) begin
            n_fail++;
            $display("FAIL writes_drained: got %0d writes outstanding, required 0", exp_wr.size());
            exp_wr.delete();
        end
    endtask

    task automatic model_reset();
        m_addr = '0; m_pfa = '0; m_lo = '0; m_buf = '0;
        m_tog = 1'b0; m_ovf = 1'b0; m_pf = 1'b0;
        m_q.delete();
        exp_wr.delete();
    endtask

    task automatic check_zero(input string name, input logic [10:0] got);
        n_tests++;
        if (got !== 11'd0) begin
            n_fail++;
            $display("FAIL %s: got %h, required 0", name, got);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_cpu_dout", 11'(cpu_dout));
        check_zero("reset_vram_addr", vram_addr);
        check_zero("reset_vram_din", 11'(vram_din));
        check_zero("reset_vram_we", 11'(vram_we));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] v;
        reset = 1'b1; cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_mode = 1'b0;
        cpu_din = 8'h00; vram_grant = 1'b0;
        for (int i = 0; i < 2048; i++) begin
            v = 8'($urandom);
            env_mem[i] = v;
            m_mem[i]   = v;
        end
        env_mem[11'h100] = 8'h5A; m_mem[11'h100] = 8'h5A;
        env_mem[11'h101] = 8'h5B; m_mem[11'h101] = 8'h5B;

        do_reset();
        stat_rd();
        data_rd();
        settle();

        // Address setup and write
        ctrl_wr(8'h2A); ctrl_wr(8'h44); data_wr(8'h41); stat_rd();
        settle();
        stat_rd(); data_wr(8'h42);
        settle();

        // Wrap at the last cell and for an out-of-range address
        ctrl_wr(8'hAF); ctrl_wr(8'h44); data_wr(8'h11); data_wr(8'h22);
        settle();
        ctrl_wr(8'hFF); ctrl_wr(8'h47); data_wr(8'h33);
        settle();

        // Blanking gate, full FIFO, overflow
        ctrl_wr(8'h00); ctrl_wr(8'h43);
        for (int i = 0; i < 4; i++) data_wr(8'hC0 + 8'(i));
        stat_rd();
        data_wr(8'hEE);
        stat_rd(); stat_rd();
        settle();

        // Read prefetch
        ctrl_wr(8'h00); ctrl_wr(8'h01);
        settle();
        stat_rd(); data_rd();
        settle();
        data_rd();
        settle();

        // Read-after-write ordering
        ctrl_wr(8'h00); ctrl_wr(8'h42); data_wr(8'h77);
        ctrl_wr(8'h00); ctrl_wr(8'h02);
        settle();
        data_rd();
        settle();

        // Grant lost every time the read reaches RD_WAIT
        ctrl_wr(8'h01); ctrl_wr(8'h02);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            vram_grant = ~vram_grant;
        end
        vram_grant = 1'b0;
        settle();
        data_rd();
        settle();

        // Reset mid-burst with the toggle left set
        ctrl_wr(8'h10); ctrl_wr(8'h41);
        data_wr(8'h01); data_wr(8'h02); data_wr(8'h03);
        ctrl_wr(8'h99);
        do_reset();
        stat_rd();
        ctrl_wr(8'h05); ctrl_wr(8'h41); data_wr(8'hAB);
        settle();

        // Randomized bursts
        for (int b = 0; b < 40; b++) begin
            int k;
            k = $urandom_range(1, 6);
            for (int j = 0; j < k; j++) begin
                case ($urandom_range(0, 3))
                    0: ctrl_wr(8'($urandom));
                    1: data_wr(8'($urandom));
                    2: data_rd();
                    default: stat_rd();
                endcase
            end
            settle();
        end
        stat_rd();
        repeat (3) @(posedge clk);

        n_tests++;
        if (exp_rd.size() != 0) begin
            n_fail++;
            $display("FAIL reads_consumed: got %0d reads outstanding, required 0", exp_rd.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
